// File: rtl/control_pipe.sv
// control_pipe: pipelined control unit for a 5-stage RV32 core.
// The D-stage decoder feeds a control bundle through the ID/EX, EX/MEM and
// MEM/WB registers. The hazard unit (load-use stall, redirect flush and
// E-stage forwarding selects) is in this module too.
module control_pipe #(
  parameter bit EXT    = 1'b1,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic              zero_e,
  output logic [3:0]        alu_control_e,
  output logic              alu_src_e,
  output logic [2:0]        imm_src_d,
  output logic              pc_src_e,
  output logic              pc_tgt_src_e,
  output logic              mem_write_m,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w,
  output logic [REG_AW-1:0] rd_w,
  output logic              illegal_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e
);

  typedef enum logic [6:0] {
    OP_LW   = 7'b0000011,
    OP_SW   = 7'b0100011,
    OP_R    = 7'b0110011,
    OP_I    = 7'b0010011,
    OP_BR   = 7'b1100011,
    OP_JAL  = 7'b1101111,
    OP_JALR = 7'b1100111,
    OP_LUI  = 7'b0110111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000
  } alu_op_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    alu_op_t    alu_control;
    logic       alu_src;
    logic       pc_tgt_src;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // D-stage instruction fields
  logic [6:0]        op_d;
  logic [2:0]        funct3_d;
  logic              funct7b5_d;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;

  assign op_d       = instr_d[6:0];
  assign funct3_d   = instr_d[14:12];
  assign funct7b5_d = instr_d[30];
  assign rs1_d      = instr_d[15 +: REG_AW];
  assign rs2_d      = instr_d[20 +: REG_AW];
  assign rd_d       = instr_d[7 +: REG_AW];

  ctrl_t   ctrl_d;
  alu_op_t alu_code;
  logic    alu_ok;
  logic    legal;

  // Combinational decode of the D-stage instruction into a control bundle
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    ctrl_d    = BUBBLE;
    imm_src_d = 3'b000;
    legal     = 1'b1;
    alu_code  = ALU_ADD;
    alu_ok    = 1'b1;

    // Shared R/I ALU decode; sub only for R-type, funct7[5] also picks sra.
    unique case (funct3_d)
      3'b000:  alu_code = (op_d == OP_R && funct7b5_d) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_code = ALU_SLT;
      3'b110:  alu_code = ALU_OR;
      3'b111:  alu_code = ALU_AND;
      3'b100:  begin alu_code = ALU_XOR; alu_ok = EXT; end
      3'b001:  begin alu_code = ALU_SLL; alu_ok = EXT; end
      3'b101:  begin alu_code = funct7b5_d ? ALU_SRA : ALU_SRL; alu_ok = EXT; end
      default: alu_ok = 1'b0;
    endcase

    case (op_d)
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b01;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src_d        = 3'b001;
      end
      OP_R: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = alu_code;
        legal              = alu_ok;
      end
      OP_I: begin
        ctrl_d.reg_write   = 1'b1;
        ctrl_d.alu_control = alu_code;
        ctrl_d.alu_src     = 1'b1;
        legal              = alu_ok;
      end
      OP_BR: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
        imm_src_d          = 3'b010;
        legal              = (funct3_d == 3'b000) || (EXT && funct3_d == 3'b001);
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        imm_src_d         = 3'b011;
      end
      OP_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.pc_tgt_src = 1'b1;
        legal             = EXT;
      end
      OP_LUI: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b11;
        ctrl_d.alu_src    = 1'b1;
        imm_src_d         = 3'b100;
        legal             = EXT;
      end
      default: legal = 1'b0;
    endcase

    // Unknown encodings travel as a bubble that only carries the illegal flag.
    if (!legal) begin
      ctrl_d         = BUBBLE;
      ctrl_d.illegal = 1'b1;
      imm_src_d      = 3'b000;
    end
  end

  // Stage registers
  ctrl_t             ctrl_e;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m;
  logic [2:0]        funct3_e;
  logic              reg_write_m;
  logic [1:0]        result_src_m;
  logic              lwstall;

  // ID/EX register: loads a bubble on reset or on a flush of E
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
    if (reset || flush_e) begin
      ctrl_e   <= BUBBLE;
      rs1_e    <= '0;
      rs2_e    <= '0;
      rd_e     <= '0;
      funct3_e <= '0;
    end else begin
      ctrl_e   <= ctrl_d;
      rs1_e    <= rs1_d;
      rs2_e    <= rs2_d;
      rd_e     <= rd_d;
      funct3_e <= funct3_d;
    end
  end

  // EX/MEM and MEM/WB registers: always advance, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
    end else begin
      reg_write_m  <= ctrl_e.reg_write;
      result_src_m <= ctrl_e.result_src;
      mem_write_m  <= ctrl_e.mem_write;
      rd_m         <= rd_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  // E-stage outputs
  assign alu_control_e = ctrl_e.alu_control;
  assign alu_src_e     = ctrl_e.alu_src;
  assign pc_tgt_src_e  = ctrl_e.pc_tgt_src;
  assign illegal_e     = ctrl_e.illegal;

  logic branch_taken;

  // Redirect and load-use detection; the two cannot coincide, so no priority
  always_comb begin
    branch_taken = ctrl_e.branch &
                   ((funct3_e == 3'b000) ? zero_e :
                    (funct3_e == 3'b001) ? ~zero_e : 1'b0);
    pc_src_e = ctrl_e.jump | branch_taken;
    // Raw rs fields compared for any D instruction: a spurious stall only costs a cycle.
    lwstall  = (ctrl_e.result_src == 2'b01) && (rd_e != '0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    stall_f  = lwstall;
    stall_d  = lwstall;
    flush_d  = pc_src_e;
    flush_e  = lwstall | pc_src_e;
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              rw_m,
    input logic [REG_AW-1:0] dst_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] dst_w
  );
    if (rw_m && dst_m != '0 && dst_m == rs)      return 2'b10;
    else if (rw_w && dst_w != '0 && dst_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Forwarding selects for both ALU operands; M is younger and wins over W
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    fwd_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed vectors for control_pipe. The stimulus process
// drives one instruction per cycle and queues hand-computed expectations
// tagged with the cycle they must appear in; the monitor compares them.
module tb_control_pipe;

  localparam logic [31:0] NOP        = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] LW_X5      = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_X6     = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] SUB_X7     = 32'h405303B3; // sub  x7,x6,x5
  localparam logic [31:0] SW_X6      = 32'h0060A223; // sw   x6,4(x1)
  localparam logic [31:0] BEQ        = 32'h00000463; // beq  x0,x0,8
  localparam logic [31:0] BNE        = 32'h00001463; // bne  x0,x0,8
  localparam logic [31:0] ADD_X0     = 32'h00208033; // add  x0,x1,x2
  localparam logic [31:0] LW_X0      = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X6_X0  = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] ADD_X6_X6  = 32'h00230333; // add  x6,x6,x2
  localparam logic [31:0] ADD_X7_X6  = 32'h006303B3; // add  x7,x6,x6
  localparam logic [31:0] JALR       = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] LUI        = 32'h123451B7; // lui  x3,0x12345
  localparam logic [31:0] SRAI       = 32'h4032D213; // srai x4,x5,3
  localparam logic [31:0] XOR_X4     = 32'h0062C233; // xor  x4,x5,x6
  localparam logic [31:0] ADDI_B30   = 32'h40028213; // addi x4,x5,1024
  localparam logic [31:0] JAL        = 32'h008000EF; // jal  x1,8
  localparam logic [31:0] BAD        = 32'hFFFFFFFF; // unknown opcode
  localparam logic [31:0] ADD_RS2_X5 = 32'h00510333; // add  x6,x2,x5

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        zero_e;

  logic [3:0] alu_control_e;
  logic       alu_src_e, pc_src_e, pc_tgt_src_e, mem_write_m, reg_write_w, illegal_e;
  logic [2:0] imm_src_d;
  logic [1:0] result_src_w, fwd_a_e, fwd_b_e;
  logic [4:0] rd_w;
  logic       stall_f, stall_d, flush_d, flush_e;

  logic [3:0] b_alu_control_e;
  logic       b_alu_src_e, b_pc_src_e, b_pc_tgt_src_e, b_mem_write_m, b_reg_write_w, b_illegal_e;
  logic [2:0] b_imm_src_d;
  logic [1:0] b_result_src_w, b_fwd_a_e, b_fwd_b_e;
  logic [4:0] b_rd_w;
  logic       b_stall_f, b_stall_d, b_flush_d, b_flush_e;

  control_pipe #(.EXT(1'b1), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .zero_e(zero_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .imm_src_d(imm_src_d),
    .pc_src_e(pc_src_e), .pc_tgt_src_e(pc_tgt_src_e), .mem_write_m(mem_write_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
    .illegal_e(illegal_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
  );

  control_pipe #(.EXT(1'b0), .REG_AW(5)) dut_base (
    .clk(clk), .reset(reset), .instr_d(instr_d), .zero_e(zero_e),
    .alu_control_e(b_alu_control_e), .alu_src_e(b_alu_src_e), .imm_src_d(b_imm_src_d),
    .pc_src_e(b_pc_src_e), .pc_tgt_src_e(b_pc_tgt_src_e), .mem_write_m(b_mem_write_m),
    .reg_write_w(b_reg_write_w), .result_src_w(b_result_src_w), .rd_w(b_rd_w),
    .illegal_e(b_illegal_e), .stall_f(b_stall_f), .stall_d(b_stall_d),
    .flush_d(b_flush_d), .flush_e(b_flush_e), .fwd_a_e(b_fwd_a_e), .fwd_b_e(b_fwd_b_e)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {
    F_ALU, F_ALU_SRC, F_IMM, F_PC_SRC, F_TGT, F_MEM_WR, F_REG_WR, F_RES, F_RD,
    F_ILL, F_STALL_F, F_STALL_D, F_FLUSH_D, F_FLUSH_E, F_FWD_A, F_FWD_B,
    F_B_ILL, F_B_PC_SRC, F_B_REG_WR, F_B_MEM_WR
  } field_e;

  typedef struct {
    int         cyc;
    field_e     fld;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   now;

  function automatic logic [4:0] probe(input field_e f);
    case (f)
      F_ALU:      return {1'b0, alu_control_e};
      F_ALU_SRC:  return {4'b0, alu_src_e};
      F_IMM:      return {2'b0, imm_src_d};
      F_PC_SRC:   return {4'b0, pc_src_e};
      F_TGT:      return {4'b0, pc_tgt_src_e};
      F_MEM_WR:   return {4'b0, mem_write_m};
      F_REG_WR:   return {4'b0, reg_write_w};
      F_RES:      return {3'b0, result_src_w};
      F_RD:       return rd_w;
      F_ILL:      return {4'b0, illegal_e};
      F_STALL_F:  return {4'b0, stall_f};
      F_STALL_D:  return {4'b0, stall_d};
      F_FLUSH_D:  return {4'b0, flush_d};
      F_FLUSH_E:  return {4'b0, flush_e};
      F_FWD_A:    return {3'b0, fwd_a_e};
      F_FWD_B:    return {3'b0, fwd_b_e};
      F_B_ILL:    return {4'b0, b_illegal_e};
      F_B_PC_SRC: return {4'b0, b_pc_src_e};
      F_B_REG_WR: return {4'b0, b_reg_write_w};
      F_B_MEM_WR: return {4'b0, b_mem_write_m};
      default:    return 5'h1f;
    endcase
  endfunction

  task automatic check(input string name, input int at, input logic [4:0] got, input logic [4:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, at, got, want);
    end
  endtask

  task automatic expect_at(input int c, input field_e f, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step(input logic [31:0] ins, input logic z, input logic r);
    @(posedge clk);
    #1;
    instr_d = ins;
    zero_e  = z;
    reset   = r;
    now     = cyc;
  endtask

  // Monitor: on every falling edge compare all expectations due this cycle
  exp_t keep[$];
  always @(negedge clk) begin
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc)
        check(sb[i].fld.name(), cyc, probe(sb[i].fld), sb[i].val);
      else if (sb[i].cyc < cyc)
        check({"stale_", sb[i].fld.name()}, sb[i].cyc, 5'h1f, sb[i].val);
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  end

  initial begin
    reset   = 1'b1;
    instr_d = NOP;
    zero_e  = 1'b0;

    // Reset sampled on two edges, released in cycle 2 with a nop in D.
    step(NOP, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0);                          // c2
    expect_at(now, F_ALU, 0);      expect_at(now, F_ALU_SRC, 0);
    expect_at(now, F_PC_SRC, 0);   expect_at(now, F_TGT, 0);
    expect_at(now, F_REG_WR, 0);   expect_at(now, F_MEM_WR, 0);
    expect_at(now, F_RES, 0);      expect_at(now, F_RD, 0);
    expect_at(now, F_ILL, 0);      expect_at(now, F_STALL_F, 0);
    expect_at(now, F_STALL_D, 0);  expect_at(now, F_FLUSH_D, 0);
    expect_at(now, F_FLUSH_E, 0);  expect_at(now, F_FWD_A, 0);
    expect_at(now, F_FWD_B, 0);    expect_at(now, F_IMM, 0);
    expect_at(now + 1, F_ALU, 0);  expect_at(now + 1, F_ALU_SRC, 1);
    expect_at(now + 1, F_REG_WR, 0);
    expect_at(now + 2, F_REG_WR, 0);
    expect_at(now + 3, F_REG_WR, 1); expect_at(now + 3, F_RD, 0);

    // Load-use: lw x5 then add x6,x5,x2 -> one stall cycle, then W forward.
    step(LW_X5, 1'b0, 1'b0);                        // c3
    expect_at(now, F_IMM, 0);      expect_at(now, F_STALL_F, 0);
    step(ADD_X6, 1'b0, 1'b0);                       // c4
    expect_at(now, F_STALL_F, 1);  expect_at(now, F_STALL_D, 1);
    expect_at(now, F_FLUSH_E, 1);  expect_at(now, F_FLUSH_D, 0);
    step(ADD_X6, 1'b0, 1'b0);                       // c5, IF-ID held
    expect_at(now, F_STALL_F, 0);  expect_at(now, F_ALU_SRC, 0);
    expect_at(now + 1, F_FWD_A, 2'b01); expect_at(now + 1, F_FWD_B, 2'b00);
    expect_at(now + 1, F_ALU, 0);       expect_at(now + 1, F_REG_WR, 1);
    expect_at(now + 1, F_RD, 5);        expect_at(now + 1, F_RES, 2'b01);

    // sub x7,x6,x5 right after add x6 -> M forward on a, no stall.
    step(SUB_X7, 1'b0, 1'b0);                       // c6
    expect_at(now, F_STALL_F, 0);
    expect_at(now + 1, F_FWD_A, 2'b10); expect_at(now + 1, F_FWD_B, 2'b00);
    expect_at(now + 1, F_ALU, 4'b0001); expect_at(now + 1, F_STALL_F, 0);

    // sw x6: S immediate, W forward on rs2, write enable two cycles later.
    step(SW_X6, 1'b0, 1'b0);                        // c7
    expect_at(now, F_IMM, 3'b001);
    expect_at(now + 1, F_ALU_SRC, 1);   expect_at(now + 1, F_FWD_A, 2'b00);
    expect_at(now + 1, F_FWD_B, 2'b01); expect_at(now + 2, F_MEM_WR, 1);

    // beq taken: redirect and flush, the next E bundle is a bubble.
    step(BEQ, 1'b0, 1'b0);                          // c8
    expect_at(now, F_IMM, 3'b010);
    step(ADD_X6, 1'b1, 1'b0);                       // c9
    expect_at(now, F_PC_SRC, 1);   expect_at(now, F_FLUSH_D, 1);
    expect_at(now, F_FLUSH_E, 1);  expect_at(now, F_TGT, 0);
    expect_at(now, F_STALL_F, 0);
    step(BEQ, 1'b1, 1'b0);                          // c10
    expect_at(now, F_PC_SRC, 0);   expect_at(now, F_FLUSH_E, 0);
    expect_at(now, F_MEM_WR, 0);
    // beq not taken, then bne: extended decode redirects, base flags illegal.
    step(BNE, 1'b0, 1'b0);                          // c11
    expect_at(now, F_PC_SRC, 0);   expect_at(now, F_FLUSH_D, 0);
    expect_at(now, F_ALU, 4'b0001);
    step(NOP, 1'b0, 1'b0);                          // c12
    expect_at(now, F_PC_SRC, 1);   expect_at(now, F_FLUSH_E, 1);
    expect_at(now, F_ILL, 0);      expect_at(now, F_ALU, 4'b0001);
    expect_at(now, F_B_ILL, 1);    expect_at(now, F_B_PC_SRC, 0);
    expect_at(now + 1, F_B_MEM_WR, 0); expect_at(now + 2, F_B_REG_WR, 0);

    // x0 is never a forwarding or stall source.
    step(ADD_X0, 1'b0, 1'b0);                       // c13
    step(LW_X0, 1'b0, 1'b0);                        // c14
    step(ADD_X6_X0, 1'b0, 1'b0);                    // c15
    expect_at(now, F_STALL_F, 0);  expect_at(now, F_FLUSH_E, 0);
    expect_at(now + 1, F_FWD_A, 0); expect_at(now + 1, F_FWD_B, 0);
    expect_at(now + 1, F_REG_WR, 1); expect_at(now + 1, F_RD, 0);
    // M over W priority when both hold rd=x6.
    step(ADD_X6_X6, 1'b0, 1'b0);                    // c16
    expect_at(now + 1, F_FWD_A, 2'b10); expect_at(now + 1, F_FWD_B, 2'b00);
    step(ADD_X7_X6, 1'b0, 1'b0);                    // c17
    expect_at(now + 1, F_FWD_A, 2'b10); expect_at(now + 1, F_FWD_B, 2'b10);

    // jalr: target from ALU, PC+4 written back to x1.
    step(JALR, 1'b0, 1'b0);                         // c18
    expect_at(now, F_IMM, 3'b000);
    expect_at(now + 1, F_PC_SRC, 1); expect_at(now + 1, F_TGT, 1);
    expect_at(now + 1, F_ALU_SRC, 1); expect_at(now + 1, F_FLUSH_D, 1);
    expect_at(now + 1, F_FLUSH_E, 1);
    expect_at(now + 3, F_REG_WR, 1); expect_at(now + 3, F_RES, 2'b10);
    expect_at(now + 3, F_RD, 1);
    step(LUI, 1'b0, 1'b0);                          // c19, flushed
    expect_at(now, F_IMM, 3'b100);
    expect_at(now + 1, F_PC_SRC, 0); expect_at(now + 1, F_TGT, 0);
    step(LUI, 1'b0, 1'b0);                          // c20
    expect_at(now + 1, F_ILL, 0);
    expect_at(now + 3, F_RES, 2'b11); expect_at(now + 3, F_RD, 3);

    // Extended ALU codes and addi with bit 30 set.
    step(SRAI, 1'b0, 1'b0);                         // c21
    expect_at(now + 1, F_ALU, 4'b1000); expect_at(now + 1, F_ALU_SRC, 1);
    step(XOR_X4, 1'b0, 1'b0);                       // c22
    expect_at(now + 1, F_ALU, 4'b0100); expect_at(now + 1, F_ALU_SRC, 0);
    step(ADDI_B30, 1'b0, 1'b0);                     // c23
    expect_at(now + 1, F_ALU, 4'b0000); expect_at(now + 1, F_ALU_SRC, 1);
    step(JAL, 1'b0, 1'b0);                          // c24
    expect_at(now, F_IMM, 3'b011);
    expect_at(now + 1, F_PC_SRC, 1); expect_at(now + 1, F_TGT, 0);
    step(NOP, 1'b0, 1'b0);                          // c25, flushed

    // Unknown opcode reaches E as an illegal bubble.
    step(BAD, 1'b0, 1'b0);                          // c26
    expect_at(now, F_IMM, 3'b000);
    expect_at(now + 1, F_ILL, 1);    expect_at(now + 1, F_PC_SRC, 0);
    expect_at(now + 1, F_ALU_SRC, 0); expect_at(now + 3, F_REG_WR, 0);
    step(NOP, 1'b0, 1'b0);                          // c27

    // Reset mid-operation discards everything in flight.
    step(LW_X5, 1'b0, 1'b0);                        // c28
    step(ADD_RS2_X5, 1'b0, 1'b1);                   // c29, rs2 load-use
    expect_at(now, F_STALL_F, 1);
    step(ADD_RS2_X5, 1'b0, 1'b0);                   // c30
    expect_at(now, F_STALL_F, 0);  expect_at(now, F_REG_WR, 0);
    expect_at(now, F_MEM_WR, 0);   expect_at(now, F_ILL, 0);
    expect_at(now + 1, F_REG_WR, 0); expect_at(now + 1, F_FWD_B, 0);
    step(NOP, 1'b0, 1'b0);                          // c31

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    foreach (sb[i]) check({"unchecked_", sb[i].fld.name()}, sb[i].cyc, 5'h1f, sb[i].val);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
